sta_job_sched: RTL and testbench
================================

Name: sta_job_sched

Overview:
- Schedules graph-analysis jobs from two independent requesters onto the single shared STA core.
- Round-robin arbitrates between the requesters and forwards the granted requester's beat stream to the core through one register stage.
- Waits for the core's worst-delay/path result and returns it tagged with the requester id.
- A watchdog recovers the schedule from stalled requesters and hung jobs.

Parameters:
- JOB_LEN, 32, number of input beats per job forwarded to the core (beats 0..15 carry node delays, all beats carry one edge).
- TIMEOUT, 1023, maximum idle cycles tolerated in FEED or WAIT before abort.
- CW, 10, watchdog counter width; must satisfy TIMEOUT < 2^CW.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req  in  2  job request, one bit per requester, level-held until granted
- gnt  out  2  one-hot grant, high for the whole FEED phase of the granted requester
- r0_valid  in  1  requester 0 beat valid
- r0_delay  in  4  requester 0 node delay
- r0_source  in  4  requester 0 edge source
- r0_destination  in  4  requester 0 edge destination
- r1_valid  in  1  requester 1 beat valid
- r1_delay  in  4  requester 1 node delay
- r1_source  in  4  requester 1 edge source
- r1_destination  in  4  requester 1 edge destination
- in_valid  out  1  to STA core, beat valid
- delay  out  4  to STA core
- source  out  4  to STA core
- destination  out  4  to STA core
- out_valid  in  1  from STA core, result beat valid
- worst_delay  in  8  from STA core, valid on first out_valid cycle
- path  in  4  from STA core, one path node per out_valid cycle
- res_valid  out  1  result beat valid
- res_id  out  1  requester owning the current result or error
- res_worst_delay  out  8  worst delay, held for all beats of a result
- res_path  out  4  path node
- err  out  1  one-cycle pulse on watchdog abort
- busy  out  1  high in any state other than ARB

Behaviour:
- Clock and reset: single clock domain; rst_n asynchronous active-low. Reset has priority in any state, including mid-FEED and mid-RESULT.
- Reset values: all outputs 0; state ARB; round-robin pointer favours r0; counters 0.
- State ARB:
  - If any req bit is high, grant the requester selected by the pointer (the pointer's requester first, otherwise the other).
  - Go to FEED; gnt goes high on the next cycle.
  - The pointer moves to the non-granted requester.
  - No req: stay in ARB.
- State FEED:
  - A beat is accepted when the granted requester's valid is high.
  - Its delay, source and destination are registered and driven to the core on the next cycle with in_valid=1. in_valid=0 in any cycle following a non-accepted cycle.
  - Beat counter increments per accepted beat. When beat JOB_LEN is accepted, go to WAIT; gnt drops on the next cycle.
  - Requesters must drive contiguous beats. Gaps are forwarded as-is (in_valid low) and are not repaired.
  - The non-granted requester's valid and data are ignored entirely.
- State WAIT:
  - The watchdog counts cycles; out_valid sampled high moves the block to RESULT.
  - The same cycle's beat is forwarded: res_valid=1, res_worst_delay=worst_delay, res_path=path, res_id=granted id.
- State RESULT:
  - Each cycle with out_valid high forwards res_valid/res_path with one-cycle latency; res_worst_delay stays held from the first beat.
  - out_valid sampled low returns the block to ARB; res_valid=0 on that next cycle.
  - A new grant may issue in the cycle after that ARB cycle.
- Watchdog:
  - Clears on entry to FEED/WAIT and on every accepted beat.
  - Increments otherwise in FEED and WAIT. On reaching TIMEOUT: err pulses one cycle with res_id=granted id, gnt drops, state returns to ARB, beat counter clears.
  - The pointer is not rolled back on abort.
- Fairness and widths:
  - Simultaneous req: the pointer decides.
  - A requester holding req continuously is granted at most every other job while the other requester is requesting.
  - All fields pass through unmodified; no arithmetic beyond the counters. The beat counter is wide enough for JOB_LEN.
- Output holding: res_* hold their last values when res_valid=0; only res_valid is qualified.

Test Plan:
- Single job: req=01, r0 streams 32 contiguous beats starting the cycle after gnt=01. Required: in_valid high 32 consecutive cycles, each beat one cycle behind its input. Core returns worst_delay=8'd37 with path 0,5,9,15 → res_valid for 4 cycles, res_id=0, res_worst_delay=37, res_path=0,5,9,15, busy low afterwards.
- Contention: req=11 out of reset. Required: gnt=01 first; after r0's result completes, gnt=10 with no intervening grant to r0, even though r0 holds req high.
- Isolation: during r0's FEED, r1 toggles r1_valid with data 4'hF. Required: core inputs carry only r0 data; r1 never granted before r0's result ends.
- Stalled requester: r0 sends 10 beats and then drops valid. Required: err pulses exactly TIMEOUT cycles after the 10th beat was accepted, res_id=0, gnt=00 next cycle, and a pending r1 is granted afterwards.
- Hung core: 32 beats fed, out_valid never rises. Required: err after TIMEOUT cycles in WAIT, block returns to ARB with res_valid never asserted.
- Reset mid-FEED: rst_n low at beat 20. Required: gnt, in_valid, res_valid, err, busy all 0 immediately. After release, a fresh 32-beat job completes normally with the pointer favouring r0.

Source files
------------

// File: rtl/sta_job_sched.sv
// Round-robin scheduler that lets two requesters share one STA core.
// It forwards the granted beat stream, returns the tagged result and aborts stalled jobs.
module sta_job_sched #(
    parameter int JOB_LEN = 32,
    parameter int TIMEOUT = 1023,
    parameter int CW      = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    input  logic       r0_valid,
    input  logic [3:0] r0_delay,
    input  logic [3:0] r0_source,
    input  logic [3:0] r0_destination,
    input  logic       r1_valid,
    input  logic [3:0] r1_delay,
    input  logic [3:0] r1_source,
    input  logic [3:0] r1_destination,
    output logic       in_valid,
    output logic [3:0] delay,
    output logic [3:0] source,
    output logic [3:0] destination,
    input  logic       out_valid,
    input  logic [7:0] worst_delay,
    input  logic [3:0] path,
    output logic       res_valid,
    output logic       res_id,
    output logic [7:0] res_worst_delay,
    output logic [3:0] res_path,
    output logic       err,
    output logic       busy
);
    localparam int BW = $clog2(JOB_LEN + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(JOB_LEN - 1);
    localparam logic [CW-1:0] WD_LAST   = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_ARB, S_FEED, S_WAIT, S_RESULT} state_t;

    state_t        state_reg, state_next;
    logic          ptr_reg, ptr_next;
    logic          gid_reg, gid_next;
    logic [BW-1:0] beat_reg, beat_next;
    logic [CW-1:0] wd_reg, wd_next;
    logic          in_valid_reg, in_valid_next;
    logic [3:0]    delay_reg, delay_next;
    logic [3:0]    source_reg, source_next;
    logic [3:0]    dest_reg, dest_next;
    logic          res_valid_reg, res_valid_next;
    logic          res_id_reg, res_id_next;
    logic [7:0]    res_wd_reg, res_wd_next;
    logic [3:0]    res_path_reg, res_path_next;
    logic          err_reg, err_next;

    logic          sel;
    logic          g_valid;
    logic [3:0]    g_delay, g_source, g_dest;
    logic          wd_hit;

    // The pointer's requester wins when it asks, otherwise the other one does.
    assign sel      = req[ptr_reg] ? ptr_reg : ~ptr_reg;
    assign g_valid  = gid_reg ? r1_valid       : r0_valid;
    assign g_delay  = gid_reg ? r1_delay       : r0_delay;
    assign g_source = gid_reg ? r1_source      : r0_source;
    assign g_dest   = gid_reg ? r1_destination : r0_destination;
    assign wd_hit   = (wd_reg == WD_LAST);

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        gid_next       = gid_reg;
        beat_next      = beat_reg;
        wd_next        = wd_reg;
        in_valid_next  = 1'b0;
        delay_next     = delay_reg;
        source_next    = source_reg;
        dest_next      = dest_reg;
        res_valid_next = 1'b0;
        res_id_next    = res_id_reg;
        res_wd_next    = res_wd_reg;
        res_path_next  = res_path_reg;
        err_next       = 1'b0;
        case (state_reg)
            S_ARB: begin
                if (|req) begin
                    gid_next   = sel;
                    ptr_next   = ~sel;
                    beat_next  = '0;
                    wd_next    = '0;
                    state_next = S_FEED;
                end
            end
            S_FEED: begin
                if (g_valid) begin
                    in_valid_next = 1'b1;
                    delay_next    = g_delay;
                    source_next   = g_source;
                    dest_next     = g_dest;
                    wd_next       = '0;
                    if (beat_reg == LAST_BEAT) begin
                        beat_next  = '0;
                        state_next = S_WAIT;
                    end else begin
                        beat_next = beat_reg + BW'(1);
                    end
                end else if (wd_hit) begin
                    err_next    = 1'b1;
                    res_id_next = gid_reg;
                    beat_next   = '0;
                    wd_next     = '0;
                    state_next  = S_ARB;
                end else begin
                    wd_next = wd_reg + CW'(1);
                end
            end
            S_WAIT: begin
                if (out_valid) begin
                    res_valid_next = 1'b1;
                    res_id_next    = gid_reg;
                    res_wd_next    = worst_delay;
                    res_path_next  = path;
                    state_next     = S_RESULT;
                end else if (wd_hit) begin
                    err_next    = 1'b1;
                    res_id_next = gid_reg;
                    beat_next   = '0;
                    wd_next     = '0;
                    state_next  = S_ARB;
                end else begin
                    wd_next = wd_reg + CW'(1);
                end
            end
            default: begin
                // worst_delay is only meaningful on the first beat, so it stays held here.
                if (out_valid) begin
                    res_valid_next = 1'b1;
                    res_path_next  = path;
                end else begin
                    state_next = S_ARB;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_ARB;
            ptr_reg       <= 1'b0;
            gid_reg       <= 1'b0;
            beat_reg      <= '0;
            wd_reg        <= '0;
            in_valid_reg  <= 1'b0;
            delay_reg     <= '0;
            source_reg    <= '0;
            dest_reg      <= '0;
            res_valid_reg <= 1'b0;
            res_id_reg    <= 1'b0;
            res_wd_reg    <= '0;
            res_path_reg  <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            gid_reg       <= gid_next;
            beat_reg      <= beat_next;
            wd_reg        <= wd_next;
            in_valid_reg  <= in_valid_next;
            delay_reg     <= delay_next;
            source_reg    <= source_next;
            dest_reg      <= dest_next;
            res_valid_reg <= res_valid_next;
            res_id_reg    <= res_id_next;
            res_wd_reg    <= res_wd_next;
            res_path_reg  <= res_path_next;
            err_reg       <= err_next;
        end
    end

    assign gnt             = (state_reg == S_FEED) ? (gid_reg ? 2'b10 : 2'b01) : 2'b00;
    assign busy            = (state_reg != S_ARB);
    assign in_valid        = in_valid_reg;
    assign delay           = delay_reg;
    assign source          = source_reg;
    assign destination     = dest_reg;
    assign res_valid       = res_valid_reg;
    assign res_id          = res_id_reg;
    assign res_worst_delay = res_wd_reg;
    assign res_path        = res_path_reg;
    assign err             = err_reg;
endmodule

// File: tb/tb_sta_job_sched.sv
// Directed bench for sta_job_sched: cycle-stamped scoreboards for core beats, results and aborts.
module tb_sta_job_sched;
    localparam int JOB_LEN = 32;
    localparam int TIMEOUT = 1023;
    localparam int CW      = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       r0_valid, r1_valid;
    logic [3:0] r0_delay, r0_source, r0_destination;
    logic [3:0] r1_delay, r1_source, r1_destination;
    logic       in_valid;
    logic [3:0] delay, source, destination;
    logic       out_valid;
    logic [7:0] worst_delay;
    logic [3:0] path;
    logic       res_valid, res_id, err, busy;
    logic [7:0] res_worst_delay;
    logic [3:0] res_path;

    sta_job_sched #(.JOB_LEN(JOB_LEN), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
        .r0_valid(r0_valid), .r0_delay(r0_delay), .r0_source(r0_source),
        .r0_destination(r0_destination),
        .r1_valid(r1_valid), .r1_delay(r1_delay), .r1_source(r1_source),
        .r1_destination(r1_destination),
        .in_valid(in_valid), .delay(delay), .source(source), .destination(destination),
        .out_valid(out_valid), .worst_delay(worst_delay), .path(path),
        .res_valid(res_valid), .res_id(res_id), .res_worst_delay(res_worst_delay),
        .res_path(res_path), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; logic [3:0] d; logic [3:0] s; logic [3:0] t;} beat_t;
    typedef struct {int cyc; logic id; logic [7:0] wd; logic [3:0] p;} res_t;
    typedef struct {int cyc; logic id;} err_t;

    beat_t core_q[$];
    res_t  res_q[$];
    err_t  err_q[$];
    beat_t mb;
    res_t  mr;
    err_t  me;

    int cyc       = 0;
    int pass_cnt  = 0;
    int check_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Output monitors: every beat seen must match the oldest expectation, including its cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid) begin
                if (core_q.size() == 0) begin
                    chk("core_unexpected_beat", 32'(in_valid), 32'd0);
                end else begin
                    mb = core_q.pop_front();
                    chk("core_cycle", 32'(cyc), 32'(mb.cyc));
                    chk("core_beat", {20'd0, delay, source, destination}, {20'd0, mb.d, mb.s, mb.t});
                end
            end
            if (res_valid) begin
                if (res_q.size() == 0) begin
                    chk("res_unexpected_beat", 32'(res_valid), 32'd0);
                end else begin
                    mr = res_q.pop_front();
                    $display("[tb] cyc=%0d result id=%0d worst=%0d path=%0d", cyc, res_id,
                             res_worst_delay, res_path);
                    chk("res_cycle", 32'(cyc), 32'(mr.cyc));
                    chk("res_id", 32'(res_id), 32'(mr.id));
                    chk("res_worst_delay", 32'(res_worst_delay), 32'(mr.wd));
                    chk("res_path", 32'(res_path), 32'(mr.p));
                end
            end
            if (err) begin
                if (err_q.size() == 0) begin
                    chk("err_unexpected", 32'(err), 32'd0);
                end else begin
                    me = err_q.pop_front();
                    $display("[tb] cyc=%0d abort id=%0d", cyc, res_id);
                    chk("err_cycle", 32'(cyc), 32'(me.cyc));
                    chk("err_id", 32'(res_id), 32'(me.id));
                    chk("err_gnt", 32'(gnt), 32'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input string tag, input logic [1:0] exp, output int waited);
        waited = 0;
        while (gnt == 2'b00 && waited < 8) begin
            tick();
            waited++;
        end
        chk(tag, 32'(gnt), 32'(exp));
    endtask

    // Drives n contiguous beats on requester id; noise makes r1 babble 4'hF beats meanwhile.
    task automatic feed(input logic id, input int n, input bit noise, output int last_cyc);
        logic [3:0] d, s, t;
        last_cyc = cyc;
        for (int i = 0; i < n; i++) begin
            d = 4'($urandom);
            s = 4'($urandom);
            t = 4'($urandom);
            if (id == 1'b0) begin
                r0_valid = 1'b1; r0_delay = d; r0_source = s; r0_destination = t;
            end else begin
                r1_valid = 1'b1; r1_delay = d; r1_source = s; r1_destination = t;
            end
            if (noise) begin
                r1_valid = i[0]; r1_delay = 4'hF; r1_source = 4'hF; r1_destination = 4'hF;
            end
            core_q.push_back('{cyc + 1, d, s, t});
            last_cyc = cyc;
            tick();
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        r1_delay = 4'h0; r1_source = 4'h0; r1_destination = 4'h0;
        $display("[tb] cyc=%0d fed %0d beats from r%0d", cyc, n, id);
    endtask

    // Core model: n result beats, worst_delay only meaningful on the first one.
    task automatic core_respond(input logic id, input logic [7:0] wd, input logic [15:0] p4,
                                input int n);
        int w;
        for (int k = 0; k < n; k++) begin
            out_valid   = 1'b1;
            worst_delay = (k == 0) ? wd : (8'hA5 ^ 8'(k));
            path        = p4[4*k +: 4];
            res_q.push_back('{cyc + 1, id, wd, p4[4*k +: 4]});
            tick();
        end
        out_valid   = 1'b0;
        worst_delay = 8'h00;
        path        = 4'h0;
        w = 0;
        while (res_q.size() != 0 && w < 10) begin
            tick();
            w++;
        end
        chk("res_drained", 32'(res_q.size()), 32'd0);
        w = 0;
        while (busy && w < 10) begin
            tick();
            w++;
        end
        chk("busy_low_after_result", 32'(busy), 32'd0);
        chk("res_valid_low_after_result", 32'(res_valid), 32'd0);
        chk("core_q_drained", 32'(core_q.size()), 32'd0);
    endtask

    task automatic wait_err(input string tag);
        int w;
        w = 0;
        while (err_q.size() != 0 && w < TIMEOUT + 50) begin
            tick();
            w++;
        end
        chk(tag, 32'(err_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        core_q.delete();
        res_q.delete();
        err_q.delete();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #20_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n, lc;
        rst_n = 1'b0; req = 2'b00;
        r0_valid = 1'b0; r0_delay = '0; r0_source = '0; r0_destination = '0;
        r1_valid = 1'b0; r1_delay = '0; r1_source = '0; r1_destination = '0;
        out_valid = 1'b0; worst_delay = '0; path = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_in_valid", 32'(in_valid), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_res_worst_delay", 32'(res_worst_delay), 32'd0);
        chk("rst_res_path", 32'(res_path), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single job from r0.
        req = 2'b01;
        wait_gnt("single_gnt", 2'b01, n);
        chk("single_gnt_latency", 32'(n), 32'd1);
        req = 2'b00;
        feed(1'b0, JOB_LEN, 1'b0, lc);
        chk("single_gnt_drop", 32'(gnt), 32'd0);
        chk("single_busy_wait", 32'(busy), 32'd1);
        repeat (3) tick();
        core_respond(1'b0, 8'd37, {4'd15, 4'd9, 4'd5, 4'd0}, 4);

        // Contention from reset with r1 babbling during r0's feed.
        do_reset();
        req = 2'b11;
        wait_gnt("contend_first_gnt", 2'b01, n);
        chk("contend_gnt_latency", 32'(n), 32'd1);
        feed(1'b0, JOB_LEN, 1'b1, lc);
        chk("contend_gnt_drop", 32'(gnt), 32'd0);
        repeat (3) tick();
        core_respond(1'b0, 8'd90, {4'd4, 4'd3, 4'd2, 4'd1}, 3);
        wait_gnt("contend_second_gnt", 2'b10, n);
        chk("contend_second_latency", 32'(n), 32'd1);
        req = 2'b01;
        feed(1'b1, JOB_LEN, 1'b0, lc);
        chk("r1_gnt_drop", 32'(gnt), 32'd0);
        repeat (2) tick();
        core_respond(1'b1, 8'd255, {8'd0, 4'd12, 4'd6}, 2);

        // Stalled requester: r0 stops after 10 beats, r1 pending.
        wait_gnt("stall_gnt", 2'b01, n);
        req = 2'b10;
        feed(1'b0, 10, 1'b0, lc);
        err_q.push_back('{lc + 1 + TIMEOUT, 1'b0});
        wait_err("stall_err_seen");
        chk("stall_err_pulse", 32'(err), 32'd0);
        wait_gnt("stall_next_gnt", 2'b10, n);

        // Hung core: r1 feeds a full job, no result ever.
        req = 2'b00;
        feed(1'b1, JOB_LEN, 1'b0, lc);
        chk("hung_gnt_drop", 32'(gnt), 32'd0);
        err_q.push_back('{lc + 1 + TIMEOUT, 1'b1});
        wait_err("hung_err_seen");
        chk("hung_busy_low", 32'(busy), 32'd0);
        chk("hung_err_pulse", 32'(err), 32'd0);

        // Reset in the middle of a feed, then a clean job.
        req = 2'b01;
        wait_gnt("midrst_gnt", 2'b01, n);
        req = 2'b00;
        feed(1'b0, 20, 1'b0, lc);
        #1;
        chk("midrst_pre_in_valid", 32'(in_valid), 32'd1);
        chk("midrst_pre_gnt", 32'(gnt), 32'd1);
        chk("midrst_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_in_valid", 32'(in_valid), 32'd0);
        chk("midrst_res_valid", 32'(res_valid), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        core_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        req = 2'b11;
        wait_gnt("postrst_gnt", 2'b01, n);
        chk("postrst_gnt_latency", 32'(n), 32'd1);
        req = 2'b00;
        feed(1'b0, JOB_LEN, 1'b0, lc);
        chk("postrst_gnt_drop", 32'(gnt), 32'd0);
        repeat (2) tick();
        core_respond(1'b0, 8'd200, {4'd7, 4'd1, 4'd2, 4'd3}, 4);

        chk("final_core_q", 32'(core_q.size()), 32'd0);
        chk("final_res_q", 32'(res_q.size()), 32'd0);
        chk("final_err_q", 32'(err_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
